// File: rtl/gif_scheduler_if.sv
// gif_scheduler_if
//   Groups the key inputs and the matrix-control outputs of gif_scheduler.
//   Signals:
//     key_next_n, key_prev_n, key_off_n : raw active-low mode keys
//     enable[3:0] : one-hot gif enable (4'b0000 = no animation owns the matrix)
//     leds[3:0]   : status display, one-hot of selected/target animation
//     busy        : high while blanking between animations
//   Modports:
//     master : key source / output observer (board top or testbench)
//     slave  : the scheduler itself
interface gif_scheduler_if;
    logic       key_next_n;
    logic       key_prev_n;
    logic       key_off_n;
    logic [3:0] enable;
    logic [3:0] leds;
    logic       busy;

    modport master (
        output key_next_n, key_prev_n, key_off_n,
        input  enable, leds, busy
    );

    modport slave (
        input  key_next_n, key_prev_n, key_off_n,
        output enable, leds, busy
    );
endinterface

// File: rtl/gif_scheduler.sv
// gif_scheduler
//   Sequences four gif animation instances that share the LED matrix.
//   Debounces the mode keys, drives a strictly one-hot enable toward the gif
//   instances, inserts an all-off blanking gap on every switch and shows the
//   selected animation on the status LEDs.
//   Ports:
//     CLOCK_50  in   system clock, all logic on rising edge
//     reset     in   synchronous active-high reset
//     bus       gif_scheduler_if.slave (keys in; enable/leds/busy out, all registered)
//     state_o   out  FSM state for debug: 0=OFF, 1=BLANK, 2=SHOW
//   Optional feature: define GIF_AUTO_CYCLE_EN to auto-advance to the next
//   animation after DWELL_CYCLES in SHOW without a key press.
module gif_scheduler #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLANK_CYCLES    = 50_000,
    parameter int DWELL_CYCLES    = 250_000_000
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    gif_scheduler_if.slave  bus,
    output logic [1:0]      state_o
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BL_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

    // Key bit order: 0 = next, 1 = prev, 2 = off.
    logic [2:0]      keys_raw;
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0]      db_q, db_d;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [DB_W-1:0] db_cnt_d [3];
    logic [2:0]      press;

    state_e          state_q, state_d;
    logic [1:0]      index_q, index_d;
    logic [1:0]      target_q, target_d;
    logic [BL_W-1:0] blank_cnt_q, blank_cnt_d;
    logic [3:0]      enable_q, enable_d;
    logic [3:0]      leds_q, leds_d;
    logic            busy_q, busy_d;
    logic            ev_auto;

    assign keys_raw = {bus.key_off_n, bus.key_prev_n, bus.key_next_n};

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Debounce: count while the synced level disagrees with the accepted
    // level; accept on the terminal count. A press is the accepted 1->0 edge,
    // flagged in the same cycle the accepted level changes.
    always_comb begin
        db_d  = db_q;
        press = 3'b000;
        for (int k = 0; k < 3; k++) begin
            db_cnt_d[k] = '0;
            if (sync2_q[k] != db_q[k]) begin
                if (db_cnt_q[k] == DB_LAST) begin
                    db_d[k]  = sync2_q[k];
                    press[k] = ~sync2_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + 1'b1;
                end
            end
        end
    end

`ifdef GIF_AUTO_CYCLE_EN
    localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);

    logic [DW_W-1:0] dwell_q, dwell_d;

    // Dwell only advances while SHOW is stable; any key press restarts it.
    assign ev_auto = (state_q == ST_SHOW) && (dwell_q == DW_LAST);

    always_comb begin
        dwell_d = dwell_q + 1'b1;
        if ((state_q != ST_SHOW) || (|press) || ev_auto) begin
            dwell_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            dwell_q <= '0;
        end else begin
            dwell_q <= dwell_d;
        end
    end
`else
    logic unused_dwell;
    assign unused_dwell = ^DWELL_CYCLES;
    assign ev_auto      = 1'b0;
`endif

    // Next state. Priority off > next > prev > auto.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        target_d    = target_q;
        blank_cnt_d = '0;
        case (state_q)
            ST_OFF: begin
                if (press[0] || press[1]) begin
                    state_d  = ST_BLANK;
                    target_d = index_q;
                end
            end
            ST_SHOW: begin
                if (press[2]) begin
                    state_d = ST_OFF;
                end else if (press[0]) begin
                    state_d  = ST_BLANK;
                    target_d = index_q + 2'd1;
                end else if (press[1]) begin
                    state_d  = ST_BLANK;
                    target_d = index_q - 2'd1;
                end else if (ev_auto) begin
                    state_d  = ST_BLANK;
                    target_d = index_q + 2'd1;
                end
            end
            ST_BLANK: begin
                // next/prev are dropped here; only off can cut the gap short.
                if (press[2]) begin
                    state_d  = ST_OFF;
                    target_d = index_q;
                end else if (blank_cnt_q == BL_LAST) begin
                    state_d = ST_SHOW;
                    index_d = target_q;
                end else begin
                    blank_cnt_d = blank_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        enable_d = 4'b0000;
        leds_d   = 4'b0000;
        busy_d   = 1'b0;
        case (state_d)
            ST_SHOW: begin
                enable_d = onehot(index_d);
                leds_d   = onehot(index_d);
            end
            ST_BLANK: begin
                leds_d = onehot(target_d);
                busy_d = 1'b1;
            end
            default: begin
                enable_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q     <= 3'b111;
            sync2_q     <= 3'b111;
            db_q        <= 3'b111;
            for (int k = 0; k < 3; k++) begin
                db_cnt_q[k] <= '0;
            end
            state_q     <= ST_OFF;
            index_q     <= 2'd0;
            target_q    <= 2'd0;
            blank_cnt_q <= '0;
            enable_q    <= 4'b0000;
            leds_q      <= 4'b0000;
            busy_q      <= 1'b0;
        end else begin
            sync1_q     <= keys_raw;
            sync2_q     <= sync1_q;
            db_q        <= db_d;
            for (int k = 0; k < 3; k++) begin
                db_cnt_q[k] <= db_cnt_d[k];
            end
            state_q     <= state_d;
            index_q     <= index_d;
            target_q    <= target_d;
            blank_cnt_q <= blank_cnt_d;
            enable_q    <= enable_d;
            leds_q      <= leds_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.enable = enable_q;
    assign bus.leds   = leds_q;
    assign bus.busy   = busy_q;
    assign state_o    = state_q;

endmodule
